// File: rtl/psum_accumulator_if.sv
// Stream bundle for psum_accumulator: partial-sum input beats and packet-total output.
// A beat or total moves on a rising edge where valid && ready; valid never waits on ready.
interface psum_accumulator_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             busy;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/psum_accumulator.sv
// Packet partial-sum accumulator: sign-extends each beat, adds it with a grouped
// carry-lookahead adder, and holds the packet total with a sticky signed-overflow flag.
module psum_accumulator #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  psum_accumulator_if.slave   bus,
  output logic [1:0]          o_dbg_state
);
  localparam int NG = ACC_W / 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_busy;

  logic [ACC_W-1:0] w_b;
  logic [ACC_W-1:0] w_p;
  logic [ACC_W-1:0] w_g;
  logic [ACC_W:0]   w_c;
  logic [NG-1:0]    w_pm;
  logic [NG-1:0]    w_gm;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;
  logic             w_in_ready;
  logic             w_beat;

  assign w_b = ACC_W'($signed(bus.in_data));

  // Per-bit P/G, 4-bit lookahead inside each nibble, group Gm/Pm chained from cin=0.
  always_comb begin
    w_p  = r_acc ^ w_b;
    w_g  = r_acc & w_b;
    w_c  = '0;
    w_pm = '0;
    w_gm = '0;
    for (int k = 0; k < NG; k++) begin
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_pm[k]    = &w_p[4*k +: 4];
      w_gm[k]    = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_c[4*k+4] = w_gm[k] | (w_pm[k] & w_c[4*k]);
    end
    w_sum = w_p ^ w_c[ACC_W-1:0];
    w_ovf = w_c[ACC_W] ^ w_c[ACC_W-1];
  end

  // Holding a total only blocks input while the consumer stalls, so packets chain without a bubble.
  assign w_in_ready = (r_state != S_HOLD) || bus.out_ready;
  assign w_beat     = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_beat) begin
            r_acc <= w_b;
            r_ovf <= 1'b0;
            if (bus.in_last) begin
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_ACC;
              r_busy  <= 1'b1;
            end
          end
        end
        S_ACC: begin
          if (w_beat) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_ovf;
            if (bus.in_last) begin
              r_state     <= S_HOLD;
              r_out_valid <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (w_beat) begin
            r_acc <= w_b;
            r_ovf <= 1'b0;
            if (!bus.in_last) begin
              r_state     <= S_ACC;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b1;
            end
          end else if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_acc;
  assign bus.out_ovf   = r_ovf;
  assign bus.busy      = r_busy;
  assign o_dbg_state   = r_state;
endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Sequential partial-sum accumulator that sits directly downstream of the subarray MAC bit-line readout and upstream of the output buffer. It accepts a packet of signed partial sums over a valid/ready stream, adds each beat into a running accumulator, and presents the packet total with a sticky signed-overflow flag. The adder is a grouped carry-lookahead adder: per-bit P/G generation feeding 4-bit lookahead groups with group Pm/Gm chained across nibbles.

## Interface
- IN_W, 8, width of signed input partial sum; 1 ≤ IN_W ≤ ACC_W.
- ACC_W, 16, accumulator width; must be a multiple of 4.
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  IN_W  signed (two's complement) partial sum.
- in_last  input  1  marks final beat of a packet; qualified by in_valid.
- out_valid  output  1  packet total available.
- out_ready  input  1  consumer accepts total.
- out_sum  output  ACC_W  packet total, modulo 2^ACC_W.
- out_ovf  output  1  sticky signed overflow over the packet.
- busy  output  1  high while a packet is partially accumulated (state ACC).

## Operation
- Beat accepted when in_valid && in_ready. Total delivered when out_valid && out_ready.
- Operand b = in_data sign-extended to ACC_W. Sum = acc + b via P = acc^b, G = acc&b per bit, 4-bit lookahead groups (coi, Pm, Gm), group carries chained with cin=0 into group 0. Result wraps modulo 2^ACC_W.
- Signed overflow per add = carry into MSB XOR carry out of MSB.
- States: IDLE, ACC, HOLD. Reset: IDLE, acc=0, ovf=0.
- IDLE: in_ready=1. On accepted beat: acc ← b (load, no add), ovf ← 0; in_last ? HOLD : ACC.
- ACC: in_ready=1. On accepted beat: acc ← acc+b, ovf ← ovf | overflow; in_last ? HOLD : ACC. No beat: hold.
- HOLD: out_valid=1; in_ready = out_ready. out_sum = acc, out_ovf = ovf, both stable while out_ready=0.
  - out_ready=1, no beat: → IDLE.
  - out_ready=1 and beat accepted same cycle: acc ← b (load), ovf ← 0; in_last ? HOLD : ACC. Back-to-back packets, no bubble.
- A first-beat load never sets ovf (IN_W ≤ ACC_W).
- busy = (state == ACC).
- Reset mid-packet: partial packet discarded, no output produced for it.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- Throughput: one beat per cycle in IDLE/ACC; one per cycle across packet boundaries when out_ready=1.
- Latency: last beat accepted at edge t → out_valid=1, out_sum final from t (visible the cycle after acceptance).
- out_valid, out_sum, out_ovf are registered; in_ready is combinational from state and out_ready only (no in_valid path).
- Adder is single-cycle combinational between acc register and next-state. No multicycle paths.
- in_last without in_valid is ignored.

## Test plan
- IN_W=8, ACC_W=16: beats 3, 5, -2(last), out_ready=1 → one cycle after last: out_valid=1, out_sum=0x0006, out_ovf=0, then IDLE.
- Single-beat packet -128 with in_last → out_sum=0xFF80, out_ovf=0, busy never asserted.
- 300 beats of 127, last on 300th → out_sum=0x94D4, out_ovf=1. Next packet of 1 beat of 1 → out_sum=0x0001, out_ovf=0 (sticky clears).
- Full carry propagation across all groups: beats -1, 1(last) → out_sum=0x0000, out_ovf=0. Beats 0x7F repeated until acc=0x7FFF region crosses: 258 beats 127 then 2(last) → out_sum=0x8000, out_ovf=1.
- Backpressure: packet 10(last), hold out_ready=0 for 5 cycles → out_valid=1, out_sum=0x000A stable, in_ready=0. Then out_ready=1 with in_valid=1, in_data=1, in_last=1 same cycle → total 0x000A consumed; next cycle out_valid=1, out_sum=0x0001.
- Reset mid-packet: beats 10, 20, then rst_n=0 for 2 cycles → all outputs at reset values immediately (asynchronous). After release, beat 7(last) → out_sum=0x0007, out_ovf=0.
